// File: rtl/sumador_acumulador.sv
// Purpose : accumulates N_SAMPLES unsigned adder results into an ACC_W-bit total with a sticky carry flag.
// Latency : acc_valid rises the cycle after the Nth accepted sample; min period N_SAMPLES+1 cycles per result.
// Backpr. : c_ready drops while a finished total waits in DONE; the total is held until enb && acc_ready.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (reset wins over everything)
//   enb             block enable; 0 freezes all state and drops c_ready
//   c_in/c_valid    incoming sample and its valid; c_ready is the matching ready
//   acc_out         running sum during a block, final sum while acc_valid=1
//   acc_valid/rdy   output handshake for the completed total
//   ovf             sticky carry out of ACC_W within the current block
//   count           samples accepted in the current block
module sumador_acumulador #(
    parameter int DATA_W    = 4,
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 6,
    parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic [DATA_W-1:0] c_in,
    input  logic              c_valid,
    output logic              c_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              ovf,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic               w_consume;
    logic               w_last;
    logic [ACC_W:0]     w_sum;

    // One extra bit on the adder captures the carry out of ACC_W for ovf.
    assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, c_in};
    assign w_accept  = enb && c_valid && c_ready;
    assign w_consume = enb && acc_ready && (r_state == S_DONE);
    // True when the sample being accepted now completes the block.
    assign w_last    = (r_count + CNT_W'(1)) == CNT_W'(N_SAMPLES);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. IDLE and ACC share the same transition rule; with
    // N_SAMPLES=1 the first accept in IDLE is already the last one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (w_consume) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        c_ready   = enb && (r_state != S_DONE);
        acc_valid = (r_state == S_DONE);
    end

    // Datapath. Accept and consume are mutually exclusive because c_ready
    // is low in DONE; c_in only reaches state through an accept, so an X on
    // c_in with c_valid=0 never lands in a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_ovf   <= r_ovf | w_sum[ACC_W];
            r_count <= r_count + CNT_W'(1);
        end else if (w_consume) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end
    end

    assign acc_out = r_acc;
    assign ovf     = r_ovf;
    assign count   = r_count;

endmodule

// File: doc/sumador_acumulador.md
Name: sumador_acumulador

Overview:
- Downstream consumer of the 4-bit adder output `c`.
- Accepts a stream of adder results over a valid/ready handshake and accumulates N_SAMPLES of them into a wider total.
- Presents the total, with a sticky overflow flag, on an output valid/ready handshake.
- Sits between the adder and any block that needs block sums, e.g. a display or logging stage.

Parameters:
- DATA_W, 4, width of incoming adder result.
- N_SAMPLES, 4, number of samples summed per result (≥1).
- ACC_W, 6, accumulator/result width. The accumulator wraps modulo 2^ACC_W.
- CNT_W, $clog2(N_SAMPLES+1), width of sample counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset. Highest priority, independent of enb.
- enb  in  1  block enable; 0 freezes all state.
- c_in  in  DATA_W  adder result (unsigned).
- c_valid  in  1  c_in is valid this cycle.
- c_ready  out  1  block can accept a sample; combinational: enb && state!=DONE.
- acc_out  out  ACC_W  running or final accumulated sum.
- acc_valid  out  1  acc_out holds a completed N_SAMPLES sum.
- acc_ready  in  1  consumer takes result.
- ovf  out  1  sticky: a carry out of ACC_W occurred in the current block.
- count  out  CNT_W  samples accepted in the current block.

Behaviour:
- Reset (rst=1 at edge): state=IDLE, acc_out=0, acc_valid=0, ovf=0, count=0. Rst overrides enb, c_valid and acc_ready, including mid-block and in DONE; partial sums are discarded.
- Accept event: enb && c_valid && c_ready at the rising edge. When it occurs:
  - acc_out <= acc_out + zero-extended c_in, modulo 2^ACC_W.
  - ovf <= ovf | carry.
  - count <= count+1.
- State IDLE (count=0):
  - accept event -> ACC, or -> DONE directly if N_SAMPLES=1.
  - no accept event -> stay in IDLE.
- State ACC:
  - accept event with count+1==N_SAMPLES -> DONE.
  - accept event otherwise -> stay in ACC.
  - no accept event (c_valid=0 or enb=0) -> hold.
- State DONE:
  - acc_valid=1 and c_ready=0; no samples are accepted and acc_out/ovf/count are frozen.
  - enb && acc_ready at edge -> IDLE; acc_out=0, ovf=0, count=0, acc_valid=0 next cycle.
- Latency: acc_valid rises on the cycle after the Nth accepted sample's edge.
- Throughput: the minimum period is N_SAMPLES+1 cycles per result. There is one dead cycle in DONE even with acc_ready held high, because c_ready=0 in DONE.
- enb=0: no state, acc_out, ovf or count change. c_ready=0. acc_ready is ignored. acc_valid holds its value.
- acc_ready outside DONE: ignored.
- acc_out during IDLE/ACC: shows the running sum but is not qualified; consumers use it only with acc_valid=1.
- Held sample during DONE: a sample presented during DONE stays pending. The upstream must hold c_valid/c_in until c_ready, and the sample is accepted in IDLE the cycle after consumption.
- X on c_in while c_valid=0 must not propagate into state.

Test Plan:
1. Reset:
   - Stimulus: rst=1 for 2 cycles with c_valid=1, c_in=4'hF, enb=1.
   - Response: acc_out=0, acc_valid=0, ovf=0, count=0; c_ready=1 after release.
2. Basic block:
   - Stimulus: enb=1, acc_ready=0; samples 1,7,3,5 on consecutive cycles.
   - Response: the cycle after the 4th edge, acc_valid=1, acc_out=16, ovf=0, count=4, c_ready=0. Values are held 3 cycles; pulse acc_ready -> next cycle acc_valid=0, acc_out=0, count=0.
3. Gaps and enable:
   - Stimulus: samples 2, then c_in=9 with enb=0, then a c_valid=0 cycle, then 2,2,2.
   - Response: 9 is ignored and count holds during the gaps; acc_out=8 with acc_valid=1.
4. Overflow:
   - Stimulus: override N_SAMPLES=8, ACC_W=6; eight samples of 15.
   - Response: ovf sets at the 5th accept (75>63); final acc_out=120 mod 64=56, ovf=1; both clear after acc_ready handshake.
5. Reset mid-block:
   - Stimulus: samples 4,4 (count=2, acc_out=8), then rst=1 one cycle, then 1,1,1,1.
   - Response: count=0 and acc_out=0 after reset; final acc_out=4, acc_valid=1.
6. Backpressure in DONE:
   - Stimulus: complete a block of 3,3,3,3 (acc_out=12), then hold c_valid=1, c_in=6 for 4 cycles with acc_ready=0, then pulse acc_ready.
   - Response: acc_out stays 12 and count stays 4 while in DONE. After consumption, the next edge accepts 6, giving acc_out=6, count=1, state ACC.
